buzzer_event_decoder: RTL and testbench

Receiving end of the zone-alarm buzzer interface. The block samples the three buzzer lines driven by the sensor/alarm controller and checks that each alarm pulse is a single-zone pulse of legal width. Each valid pulse becomes a zone event delivered over a valid/ready handshake through a 2-entry FIFO. Multi-zone, stuck and overflow conditions are flagged to the supervising logic.

---
 rtl/buzzer_event_decoder.sv | 173 +++++++++++++++++
 tb/tb_buzzer_event_decoder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buzzer_event_decoder.sv
// Zone-alarm buzzer receiver: checks single-zone pulses of legal width and queues them as zone events.
// Optional macro ZONE_COUNTERS_EN adds saturating per-zone event counters (zone_count1..3).
module buzzer_event_decoder #(
  parameter int MIN_WIDTH = 28,
  parameter int MAX_WIDTH = 34
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       buzzer1,
  input  logic       buzzer2,
  input  logic       buzzer3,
  input  logic       evt_ready,
  input  logic       err_clear,
  output logic       evt_valid,
  output logic [1:0] evt_zone,
  output logic [5:0] evt_width,
  output logic       fault_multi,
  output logic       fault_stuck,
  output logic       overflow
`ifdef ZONE_COUNTERS_EN
  ,
  output logic [7:0] zone_count1,
  output logic [7:0] zone_count2,
  output logic [7:0] zone_count3
`endif
);

  localparam logic [5:0] MIN_W = 6'(MIN_WIDTH);
  localparam logic [5:0] MAX_W = 6'(MAX_WIDTH);

  typedef enum logic [1:0] {IDLE, MEASURE, STUCK, MULTI} state_t;

  state_t     state_q, state_d;
  logic [3:1] s_bz;
  logic [3:1] latched_mask;
  logic [1:0] zone_q, zone_d;
  logic [5:0] width_q, width_d;
  logic       push;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_bz    <= '0;
      state_q <= IDLE;
      zone_q  <= '0;
      width_q <= '0;
    end else begin
      s_bz    <= {buzzer3, buzzer2, buzzer1};
      state_q <= state_d;
      zone_q  <= zone_d;
      width_q <= width_d;
    end
  end

  always_comb begin
    latched_mask = 3'b000;
    case (zone_q)
      2'd1:    latched_mask = 3'b001;
      2'd2:    latched_mask = 3'b010;
      2'd3:    latched_mask = 3'b100;
      default: latched_mask = 3'b000;
    endcase
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    zone_d  = zone_q;
    width_d = width_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        width_d = '0;
        case (s_bz)
          3'b000:  state_d = IDLE;
          3'b001:  begin state_d = MEASURE; zone_d = 2'd1; width_d = 6'd1; end
          3'b010:  begin state_d = MEASURE; zone_d = 2'd2; width_d = 6'd1; end
          3'b100:  begin state_d = MEASURE; zone_d = 2'd3; width_d = 6'd1; end
          default: state_d = MULTI;
        endcase
      end
      MEASURE: begin
        // A foreign line wins even if the latched line drops in the same sample.
        if ((s_bz & ~latched_mask) != 3'b000) begin
          state_d = MULTI;
        end else if ((s_bz & latched_mask) != 3'b000) begin
          if (width_q >= MAX_W) state_d = STUCK;
          else                  width_d = width_q + 6'd1;
        end else begin
          push    = (width_q >= MIN_W) && (width_q <= MAX_W);
          state_d = IDLE;
          width_d = '0;
        end
      end
      STUCK, MULTI: begin
        if (s_bz == 3'b000) begin
          state_d = IDLE;
          width_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Two-entry event FIFO of {zone, width}.
  logic [7:0] fifo_mem [2];
  logic       wr_ptr, rd_ptr;
  logic [1:0] count;
  logic       full, pop, push_ok, drop;

  assign full    = (count == 2'd2);
  assign pop     = evt_valid && evt_ready;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop)     rd_ptr <= ~rd_ptr;
      case ({push_ok, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; outputs are gated by evt_valid so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= {zone_q, width_q};
  end

  assign evt_valid = (count != 2'd0);
  assign evt_zone  = evt_valid ? fifo_mem[rd_ptr][7:6] : 2'd0;
  assign evt_width = evt_valid ? fifo_mem[rd_ptr][5:0] : 6'd0;

  // Sticky flags: a set in the same cycle as err_clear keeps the flag high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_multi <= 1'b0;
      fault_stuck <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      fault_multi <= (state_q == MULTI) || (fault_multi && !err_clear);
      fault_stuck <= (state_q == STUCK) || (fault_stuck && !err_clear);
      overflow    <= drop || (overflow && !err_clear);
    end
  end

`ifdef ZONE_COUNTERS_EN
  logic [7:0] zone_cnt [1:3];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int z = 1; z <= 3; z++) zone_cnt[z] <= 8'd0;
    end else begin
      for (int z = 1; z <= 3; z++) begin
        if (push_ok && (zone_q == 2'(z)) && (zone_cnt[z] != 8'hFF))
          zone_cnt[z] <= zone_cnt[z] + 8'd1;
      end
    end
  end

  assign zone_count1 = zone_cnt[1];
  assign zone_count2 = zone_cnt[2];
  assign zone_count3 = zone_cnt[3];
`endif

endmodule

// File: tb/tb_buzzer_event_decoder.sv
// Self-checking bench for buzzer_event_decoder: scoreboard of expected events plus per-scenario checks.
module tb_buzzer_event_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:1] bz = 3'b000;
  logic       evt_ready = 1'b0;
  logic       err_clear = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_zone;
  logic [5:0] evt_width;
  logic       fault_multi, fault_stuck, overflow;
`ifdef ZONE_COUNTERS_EN
  logic [7:0] zone_count1, zone_count2, zone_count3;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] sb [$];

  buzzer_event_decoder dut (
    .clk(clk), .reset(reset),
    .buzzer1(bz[1]), .buzzer2(bz[2]), .buzzer3(bz[3]),
    .evt_ready(evt_ready), .err_clear(err_clear),
    .evt_valid(evt_valid), .evt_zone(evt_zone), .evt_width(evt_width),
    .fault_multi(fault_multi), .fault_stuck(fault_stuck), .overflow(overflow)
`ifdef ZONE_COUNTERS_EN
    , .zone_count1(zone_count1), .zone_count2(zone_count2), .zone_count3(zone_count3)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every accepted event must match the oldest expected one.
  always @(negedge clk) begin
    if (reset && evt_valid && evt_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: got zone=%0d width=%0d, required no event", evt_zone, evt_width);
      end else begin
        logic [7:0] exp;
        exp = sb.pop_front();
        if ({evt_zone, evt_width} !== exp) begin
          bad++;
          $display("FAIL event_data: got zone=%0d width=%0d, required zone=%0d width=%0d",
                   evt_zone, evt_width, exp[7:6], exp[5:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int zone, input int len, input bit expect_evt);
    bz[zone] = 1'b1;
    repeat (len) tick();
    bz[zone] = 1'b0;
    if (expect_evt) sb.push_back({2'(zone), 6'(len)});
    tick();
  endtask

  task automatic clear_errors();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
    repeat (2) tick();
    total++;
    if (sb.size() != 0 || evt_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_drain: got pending=%0d valid=%b, required pending=0 valid=0", name, sb.size(), evt_valid);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    total++;
    if ({evt_valid, evt_zone, evt_width, fault_multi, fault_stuck, overflow} !== 12'd0) begin
      bad++;
      $display("FAIL reset_outputs: got valid=%b zone=%0d width=%0d fm=%b fs=%b ov=%b, required all 0",
               evt_valid, evt_zone, evt_width, fault_multi, fault_stuck, overflow);
    end
    reset = 1'b1;
    tick();
    @(negedge clk);
    total++;
    if ({evt_valid, fault_multi, fault_stuck, overflow} !== 4'd0) begin
      bad++;
      $display("FAIL post_reset_idle: got valid=%b fm=%b fs=%b ov=%b, required all 0",
               evt_valid, fault_multi, fault_stuck, overflow);
    end
    tick();
  endtask

  task automatic test_nominal();
    evt_ready = 1'b1;
    bz[2] = 1'b1;
    repeat (31) tick();
    bz[2] = 1'b0;
    sb.push_back({2'd2, 6'd31});
    @(negedge clk);
    @(negedge clk);
    total++;
    if (evt_valid !== 1'b0) begin
      bad++; $display("FAIL nominal_early: got valid=%b, required 0", evt_valid);
    end
    @(negedge clk);
    total++;
    if (evt_valid !== 1'b1 || evt_zone !== 2'd2 || evt_width !== 6'd31) begin
      bad++;
      $display("FAIL nominal_event: got valid=%b zone=%0d width=%0d, required valid=1 zone=2 width=31",
               evt_valid, evt_zone, evt_width);
    end
    @(negedge clk);
    total++;
    if (evt_valid !== 1'b0) begin
      bad++; $display("FAIL nominal_one_cycle: got valid=%b, required 0", evt_valid);
    end
    tick();
    wait_drain("nominal");
  endtask

  task automatic test_width_bounds();
    pulse(1, 27, 0);
    pulse(1, 28, 1);
    pulse(1, 34, 1);
    wait_drain("width_bounds");
    total++;
    if (fault_stuck !== 1'b0) begin
      bad++; $display("FAIL width34_not_stuck: got fault_stuck=%b, required 0", fault_stuck);
    end
  endtask

  task automatic test_stuck();
    pulse(1, 35, 0);
    repeat (3) tick();
    total++;
    if (fault_stuck !== 1'b1 || evt_valid !== 1'b0) begin
      bad++;
      $display("FAIL stuck_flag: got fault_stuck=%b valid=%b, required fault_stuck=1 valid=0", fault_stuck, evt_valid);
    end
    clear_errors();
    total++;
    if (fault_stuck !== 1'b0) begin
      bad++; $display("FAIL stuck_clear: got fault_stuck=%b, required 0", fault_stuck);
    end
  endtask

  task automatic test_multi();
    bz = 3'b101;
    repeat (4) tick();
    bz = 3'b000;
    repeat (3) tick();
    total++;
    if (fault_multi !== 1'b1 || evt_valid !== 1'b0) begin
      bad++;
      $display("FAIL multi_together: got fault_multi=%b valid=%b, required fault_multi=1 valid=0", fault_multi, evt_valid);
    end
    clear_errors();
    total++;
    if (fault_multi !== 1'b0) begin
      bad++; $display("FAIL multi_clear: got fault_multi=%b, required 0", fault_multi);
    end
    bz[1] = 1'b1;
    repeat (10) tick();
    bz[2] = 1'b1;
    repeat (3) tick();
    bz = 3'b000;
    repeat (3) tick();
    total++;
    if (fault_multi !== 1'b1 || evt_valid !== 1'b0) begin
      bad++;
      $display("FAIL multi_overlap: got fault_multi=%b valid=%b, required fault_multi=1 valid=0", fault_multi, evt_valid);
    end
    clear_errors();
    pulse(3, 31, 1);
    wait_drain("multi_recover");
  endtask

  task automatic test_back_to_back();
    pulse(1, 31, 1);
    pulse(2, 30, 1);
    pulse(3, 29, 1);
    wait_drain("back_to_back");
  endtask

  task automatic test_backpressure();
    evt_ready = 1'b0;
    pulse(1, 31, 1);
    pulse(2, 31, 1);
    pulse(3, 31, 0);
    repeat (3) tick();
    total++;
    if (evt_valid !== 1'b1 || evt_zone !== 2'd1 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL bp_overflow: got valid=%b zone=%0d ov=%b, required valid=1 zone=1 ov=1", evt_valid, evt_zone, overflow);
    end
    clear_errors();
    total++;
    if (overflow !== 1'b0 || evt_valid !== 1'b1) begin
      bad++;
      $display("FAIL bp_clear: got ov=%b valid=%b, required ov=0 valid=1", overflow, evt_valid);
    end
    evt_ready = 1'b1;
    @(negedge clk);
    total++;
    if (evt_valid !== 1'b1 || evt_zone !== 2'd1) begin
      bad++; $display("FAIL bp_pop1: got valid=%b zone=%0d, required valid=1 zone=1", evt_valid, evt_zone);
    end
    @(negedge clk);
    total++;
    if (evt_valid !== 1'b1 || evt_zone !== 2'd2) begin
      bad++; $display("FAIL bp_pop2: got valid=%b zone=%0d, required valid=1 zone=2", evt_valid, evt_zone);
    end
    @(negedge clk);
    total++;
    if (evt_valid !== 1'b0) begin
      bad++; $display("FAIL bp_empty: got valid=%b, required 0", evt_valid);
    end
    tick();
    wait_drain("backpressure");
  endtask

  task automatic test_reset_mid_pulse();
    bz = 3'b011;
    repeat (3) tick();
    bz = 3'b000;
    repeat (3) tick();
    total++;
    if (fault_multi !== 1'b1) begin
      bad++; $display("FAIL rst_precondition: got fault_multi=%b, required 1", fault_multi);
    end
    bz[2] = 1'b1;
    repeat (15) tick();
    reset = 1'b0;
    #1;
    total++;
    if ({evt_valid, evt_zone, evt_width, fault_multi, fault_stuck, overflow} !== 12'd0) begin
      bad++;
      $display("FAIL rst_mid_outputs: got valid=%b zone=%0d width=%0d fm=%b fs=%b ov=%b, required all 0",
               evt_valid, evt_zone, evt_width, fault_multi, fault_stuck, overflow);
    end
    repeat (2) tick();
    reset = 1'b1;
    repeat (14) tick();
    bz[2] = 1'b0;
    repeat (10) tick();
    total++;
    if (evt_valid !== 1'b0 || fault_multi !== 1'b0 || fault_stuck !== 1'b0) begin
      bad++;
      $display("FAIL rst_no_event: got valid=%b fm=%b fs=%b, required all 0", evt_valid, fault_multi, fault_stuck);
    end
    pulse(1, 31, 1);
    wait_drain("rst_recover");
  endtask

`ifdef ZONE_COUNTERS_EN
  task automatic test_zone_counters();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    evt_ready = 1'b1;
    for (int i = 0; i < 300; i++) pulse(1, 31, 1);
    wait_drain("counters");
    total++;
    if (zone_count1 !== 8'd255 || zone_count2 !== 8'd0 || zone_count3 !== 8'd0) begin
      bad++;
      $display("FAIL zone_counters: got c1=%0d c2=%0d c3=%0d, required c1=255 c2=0 c3=0",
               zone_count1, zone_count2, zone_count3);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_width_bounds();
    test_stuck();
    test_multi();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_pulse();
`ifdef ZONE_COUNTERS_EN
    test_zone_counters();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
